alu_seq: RTL

- Multi-byte operation sequencer wrapped around the 8-bit combinational ALU.
- Latches wide operands plus the ALU control word on a start handshake, then drives the ALU one byte per cycle, LSB first. Each byte's carryout is chained into the next byte's carryin.
- Collects result bytes and produces persistent Z/N/C/V/CMP flags.
- Sits between the instruction decoder/register file (upstream) and the ALU (downstream).

---
 rtl/alu_seq.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-byte operation sequencer around the 8-bit combinational ALU
//
// Purpose:
//   Accepts a wide operation on a start handshake, then drives the external
//   8-bit ALU one byte per cycle (LSB first), chaining carryout into the next
//   byte's carryin. Collects the result bytes and registers Z/N/C/V/CMP flags
//   from the final byte. Flags persist until the next operation completes.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, cins, len, cin0     operation request, control word, byte count-1, carry in
//   op_a, op_b                 wide operands (8*NBYTES)
//   alu_a, alu_b, alu_cins     byte operands and control word to the ALU
//   alu_oe, alu_carryin        ALU output enable and carry in
//   alu_out, alu_carryout,
//   alu_overout, alu_cmpo      ALU result byte and status
//   busy, done                 sequencer status, one-cycle completion pulse
//   result                     assembled result (unused upper bytes are 0)
//   flag_z/n/c/v/cmp           registered flags
//
// Optional feature macro: ALU_SEQ_BACK2BACK_EN
//   When defined, start is also accepted in DONE (busy low in DONE) so ops
//   can issue back to back.

module alu_seq #(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          cins,
  input  logic [1:0]          len,
  input  logic                cin0,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [7:0]          alu_cins,
  output logic                alu_oe,
  output logic                alu_carryin,
  input  logic [7:0]          alu_out,
  input  logic                alu_carryout,
  input  logic                alu_overout,
  input  logic                alu_cmpo,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_c,
  output logic                flag_v,
  output logic                flag_cmp
);

  localparam int         W        = 8 * NBYTES;
  localparam logic [1:0] LAST_MAX = 2'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_result;
  logic [7:0]   r_cins;
  logic         r_cin0;
  logic         r_carry;
  logic         r_nz;
  logic [1:0]   r_idx;
  logic [1:0]   r_last_idx;
  logic         r_flag_z;
  logic         r_flag_n;
  logic         r_flag_c;
  logic         r_flag_v;
  logic         r_flag_cmp;

  logic         w_accept;
  logic         w_run;
  logic         w_last_byte;
  logic [1:0]   w_len_clamped;
  logic [7:0]   w_a_byte;
  logic [7:0]   w_b_byte;

  assign w_run         = (r_state == S_RUN);
  assign w_last_byte   = (r_idx == r_last_idx);
  assign w_len_clamped = (len > LAST_MAX) ? LAST_MAX : len;

`ifdef ALU_SEQ_BACK2BACK_EN
  // DONE is a free slot: a new op may be accepted while done pulses.
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign busy     = w_run;
`else
  assign w_accept = start && (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
`endif

  // Byte select of the latched operands at the current index.
  always_comb begin
    w_a_byte = 8'd0;
    w_b_byte = 8'd0;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_idx == i[1:0]) begin
        w_a_byte = r_a[i*8 +: 8];
        w_b_byte = r_b[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    alu_a       = 8'd0;
    alu_b       = 8'd0;
    alu_oe      = 1'b0;
    alu_carryin = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        alu_a       = w_a_byte;
        alu_b       = w_b_byte;
        alu_oe      = 1'b1;
        // Byte 0 takes the external carry; later bytes take the chained carry.
        alu_carryin = (r_idx == 2'd0) ? r_cin0 : r_carry;
        if (w_last_byte) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = w_accept ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_cins     <= 8'd0;
      r_cin0     <= 1'b0;
      r_carry    <= 1'b0;
      r_nz       <= 1'b0;
      r_idx      <= 2'd0;
      r_last_idx <= 2'd0;
      r_flag_z   <= 1'b0;
      r_flag_n   <= 1'b0;
      r_flag_c   <= 1'b0;
      r_flag_v   <= 1'b0;
      r_flag_cmp <= 1'b0;
    end else if (w_accept) begin
      r_a        <= op_a;
      r_b        <= op_b;
      r_cins     <= cins;
      r_cin0     <= cin0;
      r_last_idx <= w_len_clamped;
      r_result   <= '0;
      r_idx      <= 2'd0;
      r_nz       <= 1'b0;
      r_carry    <= 1'b0;
    end else if (w_run) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (r_idx == i[1:0]) r_result[i*8 +: 8] <= alu_out;
      end
      r_carry <= alu_carryout;
      r_nz    <= r_nz | (alu_out != 8'd0);
      if (w_last_byte) begin
        // Final byte is still on alu_out, so fold it into Z here.
        r_flag_z   <= ~(r_nz | (alu_out != 8'd0));
        r_flag_n   <= alu_out[7];
        r_flag_c   <= alu_carryout;
        r_flag_v   <= alu_overout;
        r_flag_cmp <= alu_cmpo;
      end else begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  assign alu_cins = r_cins;
  assign result   = r_result;
  assign flag_z   = r_flag_z;
  assign flag_n   = r_flag_n;
  assign flag_c   = r_flag_c;
  assign flag_v   = r_flag_v;
  assign flag_cmp = r_flag_cmp;

endmodule
